// File: rtl/uart_frame_sequencer.sv
`timescale 1ns/1ps
// Packs each X/Y sample pair into an 8-byte frame (header, 3 X bytes, 3 Y bytes, checksum)
// and feeds it one byte at a time to a uart_tx over its DV/Done handshake.
module uart_frame_sequencer #(
  parameter int         DATA_W       = 17,
  parameter logic [7:0] HEADER       = 8'hA5,
  parameter int         GAP_CLKS     = 16,
  parameter int         TIMEOUT_CLKS = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] data_x,
  input  logic [DATA_W-1:0] data_y,
  output logic              o_tx_dv,
  output logic [7:0]        o_tx_byte,
  input  logic              i_tx_active,
  input  logic              i_tx_done,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        drop_count,
  output logic              timeout_err
);

  localparam int MAX_CLKS = (TIMEOUT_CLKS > GAP_CLKS) ? TIMEOUT_CLKS : GAP_CLKS;
  localparam int CNT_W    = $clog2(MAX_CLKS) + 1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CLKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CLKS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT,
    ST_GAP
  } state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] shadow_x, shadow_y;
  logic              pending;
  logic [7:0]        frame [8];
  logic [2:0]        idx, idx_next;
  logic [CNT_W-1:0]  timer, timer_next;
  logic              load, last_done, timeout_hit, tx_dv;
  logic [23:0]       x24, y24;
  logic [7:0]        chk;

  assign x24 = 24'(shadow_x);
  assign y24 = 24'(shadow_y);
  assign chk = x24[23:16] + x24[15:8] + x24[7:0] + y24[23:16] + y24[15:8] + y24[7:0];

  always_comb begin
    state_next  = state;
    idx_next    = idx;
    timer_next  = timer;
    load        = 1'b0;
    last_done   = 1'b0;
    timeout_hit = 1'b0;
    tx_dv       = 1'b0;
    case (state)
      // A strobe arriving in IDLE launches directly so HEADER goes out two cycles later
      ST_IDLE: if (enable && (pending || sample_valid)) state_next = ST_LOAD;
      ST_LOAD: begin
        load       = 1'b1;
        idx_next   = 3'd0;
        state_next = ST_SEND;
      end
      ST_SEND: begin
        timer_next = '0;
        if (!i_tx_active) begin
          tx_dv      = 1'b1;
          state_next = ST_WAIT;
        end
      end
      // Done is checked before the timeout so a done on the last allowed clock still counts
      ST_WAIT: begin
        if (i_tx_done) begin
          timer_next = '0;
          if (idx == 3'd7) begin
            last_done  = 1'b1;
            state_next = ST_GAP;
          end else begin
            idx_next   = idx + 3'd1;
            state_next = ST_SEND;
          end
        end else if (timer == TIMEOUT_LAST) begin
          timeout_hit = 1'b1;
          state_next  = ST_IDLE;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      ST_GAP: begin
        if (timer == GAP_LAST) state_next = ST_IDLE;
        else                   timer_next = timer + 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      idx         <= 3'd0;
      timer       <= '0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state      <= state_next;
      idx        <= idx_next;
      timer      <= timer_next;
      frame_done <= last_done;
      if (timeout_hit) timeout_err <= 1'b1;
    end
  end

  // Shadow holds the newest sample; overwriting an unconsumed one counts as a drop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_x   <= '0;
      shadow_y   <= '0;
      pending    <= 1'b0;
      drop_count <= 8'h00;
    end else if (!enable) begin
      pending <= 1'b0;
    end else if (sample_valid) begin
      shadow_x <= data_x;
      shadow_y <= data_y;
      pending  <= 1'b1;
      if (pending && !load && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end else if (load) begin
      pending <= 1'b0;
    end
  end

  // Frame registers change only in LOAD, so a frame in flight is never disturbed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) frame[i] <= 8'h00;
    end else if (load) begin
      frame[0] <= HEADER;
      frame[1] <= x24[23:16];
      frame[2] <= x24[15:8];
      frame[3] <= x24[7:0];
      frame[4] <= y24[23:16];
      frame[5] <= y24[15:8];
      frame[6] <= y24[7:0];
      frame[7] <= chk;
    end
  end

  assign o_tx_dv   = tx_dv;
  assign o_tx_byte = frame[idx];
  assign busy      = (state != ST_IDLE);

endmodule
